// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, valid/ready on both sides.
// Optional early termination is enabled by defining BOOTH_EARLY_TERM_EN.
module booth_radix4_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int XW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 4;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [AW-1:0] a_sh;
  logic [XW:0]   b_sh;
  logic [CW-1:0] cnt;

  logic [AW-1:0] term;
  logic [AW-1:0] acc_next;
  logic [XW:0]   b_next;
  logic          last;
  logic          sa;
  logic          sb;
  logic [2:0]    dig;

  assign sa  = is_signed & ina[WIDTH-1];
  assign sb  = is_signed & inb[WIDTH-1];
  assign dig = b_sh[2:0];

  // Booth digit decode; a_sh already carries the 4^i weight.
  always_comb begin
    term = '0;
    unique case (1'b1)
      (dig == 3'b001) || (dig == 3'b010): term = a_sh;
      (dig == 3'b011):                    term = a_sh << 1;
      (dig == 3'b100):                    term = -(a_sh << 1);
      (dig == 3'b101) || (dig == 3'b110): term = -a_sh;
      default:                            term = '0;
    endcase
  end

  // Accumulate, shift the multiplier window and detect the final iteration.
  always_comb begin
    acc_next = acc + term;
    b_next   = {b_sh[XW], b_sh[XW], b_sh[XW:2]};
`ifdef BOOTH_EARLY_TERM_EN
    last = (cnt == CW'(1)) || (&b_next) || (~|b_next);
`else
    last = (cnt == CW'(1));
`endif
  end

  // Control FSM with registered handshake outputs and product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out       <= '0;
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= {{(AW-WIDTH){sa}}, ina};
            b_sh     <= {{2{sb}}, inb, 1'b0};
            acc      <= '0;
            cnt      <= CW'(N);
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc  <= acc_next;
          a_sh <= a_sh << 2;
          b_sh <= b_next;
          cnt  <= cnt - CW'(1);
          if (last) begin
            out       <= acc_next[2*WIDTH-1:0];
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_radix4_multiplier.md
# booth_radix4_multiplier

Parametrised sequential radix-4 Booth multiplier, the successor to the team's unsigned radix-4 shift-add multiplier. It retires one Booth digit (two multiplier bits) per cycle and supports signed and unsigned operands, selected per operation. It has valid/ready handshakes on both input and output, a synchronous reset, and optional early termination. It sits between operand-producing datapath stages and a result consumer that may apply backpressure.

## Interface
- WIDTH, 8: operand width in bits; even, ≥4.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block idle; accepts when in_valid & in_ready at a clk edge.
- ina  input  WIDTH  multiplicand.
- inb  input  WIDTH  multiplier.
- is_signed  input  1  1: two's-complement operands; 0: unsigned. Sampled at acceptance.
- out_valid  output  1  product valid; held until consumed.
- out_ready  input  1  consumer accepts product when out_valid & out_ready.
- out  output  2*WIDTH  product, registered.
- busy  output  1  high in CALC state.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE: in_ready=1. Acceptance edge latches the operands, extended to WIDTH+2 bits (sign-extended if is_signed, else zero-extended). It clears the accumulator, sets the iteration counter N=WIDTH/2+1, and moves to CALC.
- CALC: each edge decodes digit {b[2i+1],b[2i],b[2i-1]} with b[-1]=0:
  - 000, 111 → 0
  - 001, 010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101, 110 → −A
- Each digit's term is added to the accumulator at weight 4^i. The counter decrements. On the last iteration the block goes to DONE and writes out.
- Arithmetic: terms are WIDTH+3 bits, two's complement; the accumulator is 2*WIDTH+4 bits. out is the low 2*WIDTH bits. The result is exact for all inputs in both modes; no overflow is possible.
- DONE: out_valid=1, out stable. The edge with out_ready=1 moves to IDLE and clears out_valid.
- in_valid outside IDLE is ignored and the operands are not captured.
- A product is never dropped or duplicated.
- WIDTH not even or <4: elaboration error.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out=0, state IDLE.
- rst has priority over every other input in any state. During CALC it aborts the operation with no out_valid. The block returns to IDLE on the next edge.
- Acceptance at edge t; iterations at edges t+1..t+N; out_valid is high after edge t+N.
- Latency is N=WIDTH/2+1 cycles (5 for WIDTH=8) without early termination.
- The DONE→IDLE edge does not accept new operands. in_ready rises after that edge, so the minimum initiation interval is N+2 cycles.
- out_ready may be held high; out_valid is then high for exactly one cycle.

## Configuration
- BOOTH_EARLY_TERM_EN defined:
  - After each iteration, if the remaining unprocessed multiplier bits and the guard bit are all equal (all 0 or all 1), the block goes directly to DONE.
  - out is the correctly aligned full product, identical to the full-length result.
  - At least one iteration is always performed.
- BOOTH_EARLY_TERM_EN undefined: always exactly N iterations, with fixed latency.

## Test plan
- WIDTH=8, unsigned 255×255 → out=0xFE01. out_valid rises 5 edges after acceptance; busy is high for those cycles.
- Signed −128×−128 → 0x4000. Signed −1×127 → 0xFF81. Unsigned 0x80×0xFF with is_signed=0 → 0x7F80.
- Hold out_ready=0 for 10 cycles in DONE → out and out_valid stable; in_ready=0. A pulse on in_valid with new operands is ignored. After release, exactly one product is observed.
- Assert rst after the 2nd iteration → next cycle out_valid=0, in_ready=1, out=0. A fresh 3×4 → 12 completes normally.
- With BOOTH_EARLY_TERM_EN: unsigned 200×1 → out=200 with out_valid 1 edge after acceptance. Signed 5×−1 → out=0xFFFB after 1 iteration. Without the macro, both take 5 edges.
- Randomised back-to-back ops (both modes, random out_ready) against a behavioural product model → zero mismatches and no lost or duplicated results.
